udp_rx_framer: RTL

Receive-side framing stage between the UDP/RMII core's header/byte-stream outputs and the LinuxCNC-RIO interface buffer logic. It performs the header handshake, filters on destination port, and assembles payload bytes into a BUFFER_SIZE-bit frame. It validates length and MSGID, then presents the frame with a one-cycle valid strobe plus the sender's IP and port for the reply path.

---
 rtl/udp_rx_framer_if.sv | 25 ++
 rtl/udp_rx_framer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/udp_rx_framer_if.sv
// Receive-side link between the UDP core and the framer.
// Carries the header handshake and the payload byte stream.
interface udp_rx_framer_if;
  logic        rx_head_av_i;
  logic [31:0] rx_head_i;
  logic        rx_head_rdy_o;
  logic        rx_data_av_i;
  logic [7:0]  rx_data_i;

  modport master (
    output rx_head_av_i,
    output rx_head_i,
    output rx_data_av_i,
    output rx_data_i,
    input  rx_head_rdy_o
  );

  modport slave (
    input  rx_head_av_i,
    input  rx_head_i,
    input  rx_data_av_i,
    input  rx_data_i,
    output rx_head_rdy_o
  );
endinterface

// File: rtl/udp_rx_framer.sv
// UDP receive framer: header handshake, port filter,
// payload assembly and length/MSGID validation.
module udp_rx_framer #(
  parameter int          BUFFER_SIZE = 80,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter logic [15:0] PORT        = 16'd2390,
  parameter int          DATA_WAIT   = 1024
) (
  input  logic                   clk50m,
  input  logic                   rst,
  udp_rx_framer_if.slave         rx,
  output logic [BUFFER_SIZE-1:0] frame_data_o,
  output logic                   frame_valid_o,
  output logic [31:0]            src_ip_o,
  output logic [15:0]            src_port_o,
  output logic                   err_port_o,
  output logic                   err_len_o,
  output logic                   err_msgid_o,
  output logic [15:0]            frame_count_o
);

  localparam int NBYTES = BUFFER_SIZE / 8;
  localparam int WW     = $clog2(DATA_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_IP, S_HDR_SKIP, S_HDR_PORT,
    S_WAIT, S_DATA, S_CHECK, S_DISC
  } state_t;

  state_t                 r_state, w_next;
  logic [BUFFER_SIZE-1:0] r_buf;
  logic [7:0]             r_cnt;
  logic [WW-1:0]          r_wait;
  logic [31:0]            r_cand_ip;
  logic [15:0]            r_cand_port;
  logic [BUFFER_SIZE-1:0] r_frame_data;
  logic [31:0]            r_src_ip;
  logic [15:0]            r_src_port;
  logic [15:0]            r_frame_count;
  logic                   r_rdy, r_valid;
  logic                   r_err_port, r_err_len, r_err_msgid;

  logic w_av, w_port_ok, w_wait_done;
  logic w_len_bad, w_id_bad, w_check;
  logic w_rdy, w_valid;
  logic w_err_port, w_err_len, w_err_msgid;

  assign w_av        = rx.rx_data_av_i;
  assign w_port_ok   = (rx.rx_head_i[15:0] == PORT);
  assign w_wait_done = (r_wait == WW'(DATA_WAIT - 1));
  assign w_len_bad   = (r_cnt != 8'(NBYTES));
  assign w_id_bad    = (r_buf[BUFFER_SIZE-1 -: 32] != MSGID);

  // State register
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (rx.rx_head_av_i) w_next = S_HDR_IP;
      S_HDR_IP:   w_next = S_HDR_SKIP;
      S_HDR_SKIP: w_next = S_HDR_PORT;
      S_HDR_PORT: w_next = w_port_ok ? S_WAIT : S_DISC;
      S_WAIT: begin
        if (w_av)             w_next = S_DATA;
        else if (w_wait_done) w_next = S_IDLE;
      end
      S_DATA:     if (!w_av) w_next = S_CHECK;
      S_CHECK:    w_next = S_IDLE;
      S_DISC: begin
        if (!w_av && (r_cnt != 8'd0 || w_wait_done))
          w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // Strobe decode; the verdict is taken as the payload ends
  always_comb begin
    w_check     = (r_state == S_DATA) && !w_av;
    w_rdy       = (r_state == S_IDLE) && rx.rx_head_av_i;
    w_err_port  = (r_state == S_HDR_PORT) && !w_port_ok;
    w_err_len   = (w_check && w_len_bad) ||
                  ((r_state == S_WAIT) && !w_av && w_wait_done);
    w_err_msgid = w_check && !w_len_bad && w_id_bad;
    w_valid     = w_check && !w_len_bad && !w_id_bad;
  end

  // One-cycle strobes
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_rdy       <= 1'b0;
      r_valid     <= 1'b0;
      r_err_port  <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_msgid <= 1'b0;
    end else begin
      r_rdy       <= w_rdy;
      r_valid     <= w_valid;
      r_err_port  <= w_err_port;
      r_err_len   <= w_err_len;
      r_err_msgid <= w_err_msgid;
    end
  end

  // Candidate sender address from the header words
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_cand_ip   <= '0;
      r_cand_port <= '0;
    end else begin
      if (r_state == S_HDR_IP)
        r_cand_ip <= rx.rx_head_i;
      if (r_state == S_HDR_PORT && w_port_ok)
        r_cand_port <= rx.rx_head_i[31:16];
    end
  end

  // Payload byte store, byte count and idle-wait count
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_wait <= '0;
    end else begin
      if (r_state == S_HDR_PORT) begin
        r_cnt  <= '0;
        r_wait <= '0;
      end else if (r_state == S_WAIT || r_state == S_DATA ||
                   r_state == S_DISC) begin
        if (w_av) begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          if (r_state != S_DISC) begin
            for (int k = 0; k < NBYTES; k++)
              if (r_cnt == 8'(k))
                r_buf[BUFFER_SIZE-1-8*k -: 8] <= rx.rx_data_i;
          end
        end else if (r_state != S_DATA) begin
          r_wait <= r_wait + WW'(1);
        end
      end
    end
  end

  // Published frame, sender address and good-frame count
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      r_frame_data  <= '0;
      r_src_ip      <= '0;
      r_src_port    <= '0;
      r_frame_count <= '0;
    end else if (w_valid) begin
      r_frame_data  <= r_buf;
      r_src_ip      <= r_cand_ip;
      r_src_port    <= r_cand_port;
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign rx.rx_head_rdy_o = r_rdy;
  assign frame_data_o     = r_frame_data;
  assign frame_valid_o    = r_valid;
  assign src_ip_o         = r_src_ip;
  assign src_port_o       = r_src_port;
  assign err_port_o       = r_err_port;
  assign err_len_o        = r_err_len;
  assign err_msgid_o      = r_err_msgid;
  assign frame_count_o    = r_frame_count;

endmodule
